// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Number of chunk steps per operation; guards against a zero chunk so the
    // elaboration check in the top module can report the real problem.
    function automatic int unsigned chunk_count(input int unsigned width,
                                                input int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

    // Chunk index register width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_add.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its top bit.
module chunk_add #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the incoming carry falls out by XOR.
    assign c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle a + b + cin, CHUNK bits per clock, with valid/ready on both sides.
// Define CHUNKED_ADDER_SUB_EN to add the 'sub' port (a - b via inverted B, carry-in 1).
module chunked_serial_adder
    import chunked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int unsigned IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("chunked_serial_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    state_e           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    int unsigned      base;
    logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
    logic             ch_cout, ch_cmsb;

    always_comb begin
        base = 32'(idx_q) * CHUNK;
        ch_a = a_q[base +: CHUNK];
        ch_b = b_q[base +: CHUNK];
    end

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a     (ch_a),
        .b     (ch_b),
        .cin   (carry_q),
        .sum   (ch_sum),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Next-state: accept in IDLE, one chunk per RUN cycle, hold result in DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    idx_d   = '0;
                    state_d = S_RUN;
`ifdef CHUNKED_ADDER_SUB_EN
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                end
            end
            S_RUN: begin
                sum_d[base +: CHUNK] = ch_sum;
                carry_d              = ch_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d      = ch_cout;
                    ovf_d       = ch_cout ^ ch_cmsb;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: directed vectors, backpressure, mid-op reset,
// and a random sweep over CHUNK = 16, 1, 8 at WIDTH = 16.
module tb_chunked_serial_adder;
    import chunked_adder_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    logic        clk;
    logic        rst_n, sw_rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    int          n_cmp;
    int          n_err;
    logic [17:0] sb_q[$];
    vec_t        vecs[$];
    bit          sw_done[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference {ovf, cout, sum} from a 17-bit add.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] bb;
        logic [16:0] full;
        logic        v;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {16'd0, (ms ? 1'b1 : mc)};
        v    = (ma[15] == bb[15]) && (full[15] != ma[15]);
        return {v, full[16], full[15:0]};
    endfunction

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                                input logic vs, input logic [15:0] es, input logic ec,
                                input logic eo);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
        v.esum = es; v.ecout = ec; v.eovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a posedge+1 point: returns at a negedge with out_valid high or bound hit.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            @(negedge clk);
        end
    endtask

    // Scoreboard: push on accept handshake, pop on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got result 0x%0h with no pending operation", sum);
                end else begin
                    check("sb_result", 32'({ovf, cout, sum}), 32'(sb_q.pop_front()));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        @(negedge clk);
        check("vec_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("vec_latency", 32'(lat), 32'd4);
        check("vec_result", 32'({ovf, cout, sum}), 32'({v.eovf, v.ecout, v.esum}));
        tick();
    endtask

    initial begin
        int lat;
        int guard;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        vecs.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
        vecs.push_back(mk(16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0));
        vecs.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
        vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
        vecs.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0));
        vecs.push_back(mk(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0));
        vecs.push_back(mk(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
`ifdef CHUNKED_ADDER_SUB_EN
        vecs.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
        vecs.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
        vecs.push_back(mk(16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0));
`endif

        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'({out_valid, cout, ovf, sum}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Backpressure; in_valid stays high with other operands throughout.
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        tick();
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        check("bp_result", 32'({ovf, cout, sum}), 32'({1'b0, 1'b0, 16'h2144}));
        repeat (5) begin
            tick();
            @(negedge clk);
            check("bp_hold", 32'({in_ready, out_valid, ovf, cout, sum}),
                  32'({1'b0, 1'b1, 1'b0, 1'b0, 16'h2144}));
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("bp_back_idle", 32'({in_ready, out_valid}), 32'b10);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp2_latency", 32'(lat), 32'd4);
        check("bp2_result", 32'({ovf, cout, sum}), 32'({1'b0, 1'b1, 16'h9D9C}));
        tick();

        // Reset while idx == 2 in RUN.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_idx", 32'(u_dut.idx_q), 32'd2);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", 32'(u_dut.state_q), 32'(S_IDLE));
        check("rst_outputs", 32'({out_valid, cout, ovf, sum}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) begin
            tick();
            @(negedge clk);
            check("rst_no_valid", 32'(out_valid), 32'd0);
        end
        tick();

        guard = 0;
        while (!(sw_done[0] && sw_done[1] && sw_done[2]) && guard < 40000) begin
            @(posedge clk);
            guard++;
        end
        check("sweep_done", 32'({sw_done[0], sw_done[1], sw_done[2]}), 32'b111);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        sw_rst_n = 1'b0;
        tick(); tick();
        sw_rst_n = 1'b1;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int unsigned CH  = (gi == 0) ? 16 : ((gi == 1) ? 1 : 8);
        localparam int unsigned NCH = 16 / CH;

        logic        iv, ir, ov, orr, sc, sco, sov;
        logic [15:0] sa, sb, ss;
        logic [17:0] sq[$];

        chunked_serial_adder #(.WIDTH(16), .CHUNK(CH)) u_sw (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (sa),
            .b         (sb),
            .cin       (sc),
`ifdef CHUNKED_ADDER_SUB_EN
            .sub       (1'b0),
`endif
            .out_valid (ov),
            .out_ready (orr),
            .sum       (ss),
            .cout      (sco),
            .ovf       (sov)
        );

        initial begin
            int lat;
            iv = 1'b0; orr = 1'b1; sa = '0; sb = '0; sc = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            for (int n = 0; n < 1000; n++) begin
                sa = 16'($urandom); sb = 16'($urandom); sc = 1'($urandom); iv = 1'b1;
                @(negedge clk);
                if (ir) sq.push_back(model(sa, sb, sc, 1'b0));
                tick();
                iv = 1'b0;
                lat = 0;
                @(negedge clk);
                while (!ov && lat < 40) begin
                    tick();
                    lat++;
                    @(negedge clk);
                end
                check($sformatf("sweep_c%0d_latency", CH), 32'(lat), 32'(NCH));
                if (sq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sweep_c%0d_accept: in_ready low in idle", CH);
                end else begin
                    check($sformatf("sweep_c%0d_result", CH), 32'({sov, sco, ss}),
                          32'(sq.pop_front()));
                end
                tick();
            end
            sw_done[gi] = 1'b1;
        end
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle parametrised adder. Computes a + b + cin over WIDTH bits, CHUNK bits per clock, carrying between chunks in a register.
- Trades latency for area against the flat ripple adders. Use it on wide datapaths where a full-width carry chain does not meet timing.
- Valid/ready handshake on both input and output, so it drops into streaming datapaths.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits added per cycle. Must satisfy WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH. Violations are an elaboration error.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of bit WIDTH-1.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock domain. Reset is synchronous, active-low on rst_n.
- NCHUNK = WIDTH/CHUNK. Chunk index register idx is $clog2(NCHUNK) bits wide, minimum 1.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch a, b and cin (carry reg = cin), set idx=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, chunk idx of a and b plus the carry reg is written into sum[idx*CHUNK +: CHUNK], and the carry reg takes the chunk carry-out. If idx==NCHUNK-1, also capture cout and ovf and go to DONE; otherwise idx++.
  - DONE: out_valid=1, in_ready=0. sum, cout and ovf are held stable. On out_ready, go to IDLE.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
- Minimum initiation interval: NCHUNK+2 cycles, with out_ready held high.
- in_ready depends only on state (combinational); it does not depend on in_valid.
- Chunks not yet computed hold their previous value. They are not observable, because out_valid=0.
- CHUNK==WIDTH: one RUN cycle, latency 1.
- in_valid asserted in RUN or DONE is ignored: no accept, no corruption of latched operands.
- out_ready outside DONE has no effect.
- Reset values: state=IDLE, idx=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0. in_ready is 1 in the first cycle after reset release.
- Reset mid-operation aborts the operation. No out_valid is produced for it.
- Arithmetic is modulo 2^WIDTH. The carry beyond WIDTH appears only on cout.

Optional Feature:
- Macro: CHUNKED_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched on accept.
  - When sub=1, B is latched bit-inverted and the initial carry is forced to 1; cin is ignored. The result is a-b.
  - cout=1 means no borrow. ovf is signed subtraction overflow.
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Package chunked_adder_pkg holds:
  - state enum {S_IDLE, S_RUN, S_DONE} (2-bit);
  - a function computing NCHUNK and idx width.
- One sub-module, chunk_add (combinational CHUNK-bit adder).
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb, where c_msb is the carry into the chunk's top bit (needed for ovf).
- FSM, carry register and operand latch stay in chunked_serial_adder.

Test Plan:
- WIDTH=16, CHUNK=4, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. out_valid exactly 4 cycles after accept.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x0F0F, cin=1 -> sum=0x2144, cout=0, ovf=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf held constant, in_ready=0, a second in_valid ignored. out_ready=1 -> IDLE next cycle, then the new accept.
- Reset: rst_n=0 for one cycle while idx=2 in RUN -> out_valid never asserts for that operation; state, sum, cout and ovf read reset values; in_ready=1 in the first cycle after reset release.
- Config sweep WIDTH=16 with CHUNK=16, CHUNK=1, CHUNK=8: 1000 random operands -> sum and cout match a 17-bit reference sum; latency = NCHUNK.
- With CHUNKED_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
